// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank: op decode, readout sizing.
package counter_bank_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int WORD_DEF  = 16;
    localparam int NWORDS    = WIDTH_DEF / WORD_DEF;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_LOAD  = 3'd2,
        OP_INC   = 3'd3,
        OP_DEC   = 3'd4
    } op_e;

    // Select width that never collapses to zero bits for single-entry selects.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/counter_bank_if.sv
// Host-side trigger/wire bundle for the counter bank.
interface counter_bank_if import counter_bank_pkg::*; #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int WORD  = 16
) ();
    localparam int CHW = sel_w(NCH);
    localparam int WW  = sel_w(WIDTH / WORD);

    logic [NCH-1:0]   ch_clear;
    logic [NCH-1:0]   ch_up;
    logic [NCH-1:0]   ch_down;
    logic [NCH-1:0]   ch_load;
    logic [WIDTH-1:0] load_value;
    logic [NCH-1:0]   sat_mode;
    logic [NCH-1:0]   free_run;
    logic [NCH-1:0]   tc_clear;
    logic             snap;
    logic [CHW-1:0]   rd_ch;
    logic [WW-1:0]    rd_word;
    logic [WORD-1:0]  rd_data;
    logic             snap_valid;
    logic [NCH-1:0]   tc_flag;
    logic [NCH-1:0]   ch_zero;

    modport master (
        output ch_clear, ch_up, ch_down, ch_load, load_value, sat_mode,
               free_run, tc_clear, snap, rd_ch, rd_word,
        input  rd_data, snap_valid, tc_flag, ch_zero
    );

    modport slave (
        input  ch_clear, ch_up, ch_down, ch_load, load_value, sat_mode,
               free_run, tc_clear, snap, rd_ch, rd_word,
        output rd_data, snap_valid, tc_flag, ch_zero
    );
endinterface

// File: rtl/counter_bank_chan.sv
// One counter channel: op decode, wrap/saturate update, sticky terminal-count
// flag, zero flag and snapshot shadow.
module counter_bank_chan import counter_bank_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             ti_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             sat_mode,
    input  logic             free_run,
    input  logic             tc_clear,
    input  logic             snap,
    output logic [WIDTH-1:0] shadow,
    output logic             tc_flag,
    output logic             ch_zero
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_evt;
    logic             inc;
    op_e              op;

    // up and free_run merge into one increment; opposing requests cancel.
    assign inc = up | free_run;

    always_comb begin
        op = OP_HOLD;
        if (clear)             op = OP_CLEAR;
        else if (load)         op = OP_LOAD;
        else if (inc && !down) op = OP_INC;
        else if (down && !inc) op = OP_DEC;
    end

    always_comb begin
        count_nxt = count;
        tc_evt    = 1'b0;
        case (op)
            OP_CLEAR: count_nxt = '0;
            OP_LOAD:  count_nxt = load_value;
            OP_INC: begin
                if (&count) begin
                    tc_evt    = 1'b1;
                    count_nxt = sat_mode ? count : '0;
                end else begin
                    count_nxt = count + ONE;
                end
            end
            OP_DEC: begin
                if (count == '0) begin
                    tc_evt    = 1'b1;
                    count_nxt = sat_mode ? count : '1;
                end else begin
                    count_nxt = count - ONE;
                end
            end
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            count   <= '0;
            shadow  <= '0;
            tc_flag <= 1'b0;
            ch_zero <= 1'b1;
        end else begin
            count   <= count_nxt;
            ch_zero <= (count_nxt == '0);
            // A new event outranks a same-edge clear.
            tc_flag <= tc_evt | (tc_flag & ~tc_clear);
            if (snap) shadow <= count;
        end
    end
endmodule

// File: rtl/counter_bank.sv
// Bank of NCH up/down counters with coherent snapshot readout in WORD slices.
module counter_bank import counter_bank_pkg::*; #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int WORD  = 16
) (
    input logic          ti_clk,
    input logic          reset,
    counter_bank_if.slave bus
);
    localparam int NW    = WIDTH / WORD;
    localparam int CHW   = sel_w(NCH);
    localparam int WW    = sel_w(NW);
    localparam int NCH_P = 1 << CHW;
    localparam int NW_P  = 1 << WW;

    // Padded to the full select range so out-of-range selects read zero.
    logic [NCH_P-1:0][WIDTH-1:0]  shad_pad;
    logic [NW_P-1:0][WORD-1:0]    slices;

    for (genvar i = 0; i < NCH_P; i++) begin : g_ch
        if (i < NCH) begin : g_live
            counter_bank_chan #(.WIDTH(WIDTH)) u_chan (
                .ti_clk     (ti_clk),
                .reset      (reset),
                .clear      (bus.ch_clear[i]),
                .up         (bus.ch_up[i]),
                .down       (bus.ch_down[i]),
                .load       (bus.ch_load[i]),
                .load_value (bus.load_value),
                .sat_mode   (bus.sat_mode[i]),
                .free_run   (bus.free_run[i]),
                .tc_clear   (bus.tc_clear[i]),
                .snap       (bus.snap),
                .shadow     (shad_pad[i]),
                .tc_flag    (bus.tc_flag[i]),
                .ch_zero    (bus.ch_zero[i])
            );
        end else begin : g_pad
            assign shad_pad[i] = '0;
        end
    end

    always_comb begin
        slices           = '0;
        slices[NW-1:0]   = shad_pad[bus.rd_ch];
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            bus.rd_data    <= '0;
            bus.snap_valid <= 1'b0;
        end else begin
            bus.rd_data <= slices[bus.rd_word];
            if (bus.snap) bus.snap_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_counter_bank.sv
// Directed plan plus randomized traffic against an arithmetic reference model.
module tb_counter_bank;
    localparam int NCH   = 5;
    localparam int WIDTH = 32;
    localparam int WORD  = 16;
    localparam int CHW   = 3;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic ti_clk = 1'b0;
    logic reset  = 1'b1;
    logic chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    counter_bank_if #(.NCH(NCH), .WIDTH(WIDTH), .WORD(WORD)) bus ();

    counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .WORD(WORD)) dut (
        .ti_clk (ti_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 ti_clk = ~ti_clk;

    logic [WIDTH-1:0] m_cnt  [NCH];
    logic [WIDTH-1:0] m_shad [NCH];
    logic [NCH-1:0]   m_tc, m_zero;
    logic [WORD-1:0]  m_rd;
    logic             m_sv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the counters, range-checked.
    task automatic model_step();
        int     rc;
        longint v;
        logic   inc, dec, evt;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = '0; m_shad[i] = '0;
            end
            m_tc = '0; m_zero = '1; m_rd = '0; m_sv = 1'b0;
            return;
        end
        rc = int'(bus.rd_ch);
        m_rd = (rc < NCH) ? 16'((m_shad[rc] >> (WORD * int'(bus.rd_word))) & 32'hFFFF) : 16'h0;
        if (bus.snap) begin
            for (int i = 0; i < NCH; i++) m_shad[i] = m_cnt[i];
            m_sv = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            evt = 1'b0;
            if (bus.ch_clear[i])     m_cnt[i] = '0;
            else if (bus.ch_load[i]) m_cnt[i] = bus.load_value;
            else begin
                inc = bus.ch_up[i] | bus.free_run[i];
                dec = bus.ch_down[i];
                v = longint'(m_cnt[i]);
                if (inc && !dec) v = v + 1;
                if (dec && !inc) v = v - 1;
                if (v > MAXV || v < 0) begin
                    evt = 1'b1;
                    if (!bus.sat_mode[i]) m_cnt[i] = 32'(v & MAXV);
                end else begin
                    m_cnt[i] = 32'(v);
                end
            end
            m_tc[i]   = evt | (m_tc[i] & ~bus.tc_clear[i]);
            m_zero[i] = (m_cnt[i] == 0);
        end
    endtask

    always @(negedge ti_clk) begin
        if (chk_en) begin
            chk("rd_data",    32'(bus.rd_data),    32'(m_rd));
            chk("snap_valid", 32'(bus.snap_valid), 32'(m_sv));
            chk("tc_flag",    32'(bus.tc_flag),    32'(m_tc));
            chk("ch_zero",    32'(bus.ch_zero),    32'(m_zero));
        end
    end

    task automatic cyc();
        @(posedge ti_clk);
        model_step();
        @(negedge ti_clk);
    endtask

    task automatic pulses_off();
        bus.ch_clear = '0; bus.ch_up = '0; bus.ch_down = '0; bus.ch_load = '0;
        bus.tc_clear = '0; bus.snap = 1'b0;
    endtask

    task automatic do_snap();
        bus.snap = 1'b1; cyc(); bus.snap = 1'b0;
    endtask

    task automatic read_chk(input int ch, input int w, input logic [15:0] exp);
        bus.rd_ch = CHW'(ch); bus.rd_word = 1'(w);
        cyc();
        chk($sformatf("read ch%0d w%0d", ch, w), 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        pulses_off();
        bus.load_value = '0; bus.sat_mode = '0; bus.free_run = '0;
        bus.rd_ch = '0; bus.rd_word = '0;
        reset = 1'b1;
        cyc(); chk_en = 1'b1; cyc();
        chk("reset ch_zero", 32'(bus.ch_zero), 32'h1F);
        chk("reset snap_valid", 32'(bus.snap_valid), 32'h0);
        reset = 1'b0;

        do_snap();
        chk("snap_valid set", 32'(bus.snap_valid), 32'h1);
        read_chk(0, 0, 16'h0000);
        read_chk(0, 1, 16'h0000);

        // ch0 wrap at the top
        bus.load_value = 32'hFFFF_FFFE; bus.ch_load[0] = 1'b1; cyc(); pulses_off();
        bus.ch_up[0] = 1'b1; cyc();
        chk("model ch0 max", m_cnt[0], 32'hFFFF_FFFF);
        chk("ch0 tc before wrap", 32'(bus.tc_flag[0]), 32'h0);
        cyc(); pulses_off();
        chk("model ch0 wrapped", m_cnt[0], 32'h0);
        chk("ch0 tc on wrap", 32'(bus.tc_flag[0]), 32'h1);
        bus.tc_clear[0] = 1'b1; cyc(); pulses_off();
        chk("ch0 tc cleared", 32'(bus.tc_flag[0]), 32'h0);

        // ch1 saturate at both ends
        bus.sat_mode[1] = 1'b1;
        bus.ch_clear[1] = 1'b1; cyc(); pulses_off();
        bus.ch_down[1] = 1'b1; cyc(); pulses_off();
        chk("ch1 sat low tc", 32'(bus.tc_flag[1]), 32'h1);
        chk("ch1 sat low zero", 32'(bus.ch_zero[1]), 32'h1);
        bus.load_value = 32'hFFFF_FFFF; bus.ch_load[1] = 1'b1; cyc(); pulses_off();
        bus.ch_up[1] = 1'b1; cyc(); pulses_off();
        chk("model ch1 sat high", m_cnt[1], 32'hFFFF_FFFF);
        do_snap();
        read_chk(1, 0, 16'hFFFF);
        read_chk(1, 1, 16'hFFFF);

        // ch2 free-run: never +2, up+down holds
        bus.ch_clear[2] = 1'b1; cyc(); pulses_off();
        bus.free_run[2] = 1'b1;
        for (int k = 0; k < 101; k++) begin
            bus.ch_up[2] = (k % 7 == 0); bus.ch_down[2] = (k == 50);
            cyc();
        end
        pulses_off(); bus.free_run[2] = 1'b0;
        chk("model ch2 count", m_cnt[2], 32'd100);
        do_snap();
        read_chk(2, 0, 16'h0064);
        read_chk(2, 1, 16'h0000);

        // ch3 priority and tc set-vs-clear
        bus.load_value = 32'h1234_5678;
        bus.ch_clear[3] = 1'b1; bus.ch_load[3] = 1'b1; bus.ch_up[3] = 1'b1; cyc(); pulses_off();
        chk("ch3 clear wins", 32'(bus.ch_zero[3]), 32'h1);
        bus.ch_load[3] = 1'b1; bus.ch_up[3] = 1'b1; cyc(); pulses_off();
        chk("model ch3 load wins", m_cnt[3], 32'h1234_5678);
        bus.load_value = 32'hFFFF_FFFF; bus.ch_load[3] = 1'b1; cyc(); pulses_off();
        bus.ch_up[3] = 1'b1; bus.tc_clear[3] = 1'b1; cyc(); pulses_off();
        chk("ch3 set beats clear", 32'(bus.tc_flag[3]), 32'h1);
        bus.tc_clear[3] = 1'b1; cyc(); pulses_off();
        chk("ch3 tc cleared", 32'(bus.tc_flag[3]), 32'h0);

        // snapshot is pre-update and coherent across the carry
        bus.load_value = 32'h0000_FFFF; bus.ch_load[0] = 1'b1; cyc(); pulses_off();
        bus.ch_up[0] = 1'b1; bus.snap = 1'b1; cyc(); pulses_off();
        read_chk(0, 0, 16'hFFFF);
        read_chk(0, 1, 16'h0000);
        read_chk(NCH, 0, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            pulses_off();
            for (int i = 0; i < NCH; i++) begin
                bus.ch_clear[i] = ($urandom_range(0, 31) == 0);
                bus.ch_load[i]  = ($urandom_range(0, 15) == 0);
                bus.ch_up[i]    = ($urandom_range(0, 2) == 0);
                bus.ch_down[i]  = ($urandom_range(0, 2) == 0);
                bus.tc_clear[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) bus.sat_mode[i] = ~bus.sat_mode[i];
                if ($urandom_range(0, 31) == 0) bus.free_run[i] = ~bus.free_run[i];
            end
            r = $urandom_range(0, 4);
            case (r)
                0: bus.load_value = 32'h0;
                1: bus.load_value = 32'hFFFF_FFFF;
                2: bus.load_value = 32'hFFFF_FFFE;
                3: bus.load_value = 32'h1;
                default: bus.load_value = $urandom;
            endcase
            bus.snap    = ($urandom_range(0, 7) == 0);
            bus.rd_ch   = CHW'($urandom_range(0, 7));
            bus.rd_word = 1'($urandom_range(0, 1));
            reset       = ($urandom_range(0, 299) == 0);
            cyc();
        end
        pulses_off();
        reset = 1'b1; bus.ch_up = '1; bus.snap = 1'b1; cyc();
        reset = 1'b0; pulses_off();
        chk("final reset ch_zero", 32'(bus.ch_zero), 32'h1F);
        chk("final reset tc", 32'(bus.tc_flag), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
